// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, start/done handshake.
// Optional signed mode (sgn port, magnitude iteration + sign fix-up) under `ifdef DIV_SIGNED_EN.
module div_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Handshake: start is taken only when busy==0 (IDLE or FIN); done is a
  // one-cycle pulse in FIN, and results stay stable until the next done.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_FIN} state_e;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             op_signed;
`ifdef DIV_SIGNED_EN
  assign op_signed = sgn;
`else
  assign op_signed = 1'b0;
`endif

  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  assign dvd_neg = op_signed & dividend[WIDTH-1];
  assign dsr_neg = op_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
  assign dsr_mag = dsr_neg ? (~divisor + ONE) : divisor;

  // Partial remainder is kept one bit wider during the trial so divisors
  // with the MSB set still divide correctly.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next, q_next, q_fix, r_fix;
  assign shifted   = {rem_q, q_q[WIDTH-1]};
  assign trial     = {1'b0, shifted} - {2'b00, div_q};
  assign no_borrow = ~trial[WIDTH+1];
  assign rem_next  = no_borrow ? WIDTH'(trial) : WIDTH'(shifted);
  assign q_next    = {q_q[WIDTH-2:0], no_borrow};
  assign q_fix     = negq_q ? (~q_next + ONE) : q_next;
  assign r_fix     = negr_q ? (~rem_next + ONE) : rem_next;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    rem_d       = rem_q;
    div_d       = div_q;
    dvd_d       = dvd_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d = (divisor == '0) ? S_ZERO : S_RUN;
          cnt_d   = '0;
          q_d     = dvd_mag;
          rem_d   = '0;
          div_d   = dsr_mag;
          dvd_d   = dividend;
          negq_d  = dvd_neg ^ dsr_neg;
          negr_d  = dvd_neg;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        q_d   = q_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d     = S_FIN;
          quotient_d  = q_fix;
          remainder_d = r_fix;
          dbz_d       = 1'b0;
        end
      end
      S_ZERO: begin
        state_d     = S_FIN;
        quotient_d  = '1;
        remainder_d = dvd_q;
        dbz_d       = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      dvd_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      dvd_q       <= dvd_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_ZERO);
  assign done        = (state_q == S_FIN);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed vectors plus random unsigned pairs, scoreboarded
// against a queue of expected results and done cycles.
module tb_div_iter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
`ifdef DIV_SIGNED_EN
  logic         sgn = 1'b0;
`endif
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
`ifdef DIV_SIGNED_EN
    .sgn(sgn),
`endif
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]  cyc;
    logic         dbz;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("issue_wait_busy", {31'b0, busy}, 32'd0);
    start = 1'b1;
    dividend = n;
    divisor = d;
`ifdef DIV_SIGNED_EN
    sgn = s;
`else
    if (s) $display("note: signed vector issued in unsigned build");
`endif
    @(posedge clk);
    #1;
    e.cyc = cyc + ((d == '0) ? 1 : W);
    e.dbz = edbz;
    e.q = eq;
    e.r = er;
    exp_q.push_back(e);
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_q"}, {16'b0, quotient}, 32'd0);
    chk({tag, "_r"}, {16'b0, remainder}, 32'd0);
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] n, d;
    int guard;

    // monitor: pops an expectation on every done pulse
    fork
      forever begin
        @(negedge clk);
        if (rst_n && done) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 q=0x%0h cyc=%0d", quotient, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("quotient", {16'b0, quotient}, {16'b0, e.q});
            chk("remainder", {16'b0, remainder}, {16'b0, e.r});
            chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0);
    issue(16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1);
    issue(16'd0, 16'd5, 1'b0, 16'd0, 16'd0, 1'b0);
    issue(16'd5, 16'd7, 1'b0, 16'd0, 16'd5, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 16'd1, 16'd0, 1'b0);
    issue(16'hFFFE, 16'hFFFF, 1'b0, 16'd0, 16'hFFFE, 1'b0);
    issue(16'hFFFF, 16'h8000, 1'b0, 16'd1, 16'h7FFF, 1'b0);
    issue(16'h8000, 16'hFFFF, 1'b0, 16'd0, 16'h8000, 1'b0);

    // ignored start mid-RUN, then a start in the FIN cycle
    issue(16'd1000, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    dividend = 16'd7;
    divisor = 16'd0;
    @(negedge clk);
    start = 1'b0;
    issue(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'd0, 1'b0);
    issue(16'd0, 16'd0, 1'b0, 16'hFFFF, 16'd0, 1'b1);

    // reset mid-operation
    issue(16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_idle_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_idle_outputs("post_abort");
    issue(16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0);

`ifdef DIV_SIGNED_EN
    issue(16'hFFF9, 16'd2, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0);
    issue(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0, 1'b0);
    issue(16'd7, 16'hFFFE, 1'b1, 16'hFFFD, 16'd1, 1'b0);
    issue(16'hFFF9, 16'hFFFE, 1'b1, 16'd3, 16'hFFFF, 1'b0);
    issue(16'hFFF9, 16'd0, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1);
    issue(16'hFFF9, 16'd2, 1'b0, 16'h7FFC, 16'd1, 1'b0);
`endif

    for (int i = 0; i < 1000; i++) begin
      n = W'($urandom_range(0, 65535));
      d = (i % 2 == 0) ? W'($urandom_range(1, 255)) : W'($urandom_range(0, 65535));
      if (d == '0) issue(n, d, 1'b0, 16'hFFFF, n, 1'b1);
      else         issue(n, d, 1'b0, n / d, n % d, 1'b0);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
